riscv_ex_operand_stage: RTL and testbench
=========================================

RISCV_EX_OPERAND_STAGE -- requirements
Module: riscv_ex_operand_stage

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Ports, name  direction  width  meaning:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  hold the ID/EX register.
- flush  in  1  load a bubble.
- id_valid  in  1  ID-stage instruction valid.
- id_pc  in  32  instruction PC.
- id_rs1_data, id_rs2_data  in  32 each  register-file read data.
- id_imm  in  32  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_opcode  in  7;  id_funct3  in  3;  id_funct7b5  in  1  instruction bit 30.
- mem_rd  in  5;  mem_regwrite  in  1;  mem_result  in  32  EX/MEM producer.
- wb_rd  in  5;  wb_regwrite  in  1;  wb_result  in  32  MEM/WB producer.
- ex_valid  out  1  EX-stage instruction valid.
- SrcA, SrcB  out  32 each  ALU operands.
- Ainv, Binv  out  1 each;  ALUsel  out  3  ALU opcode fields.
- ex_rd  out  5;  ex_regwrite  out  1;  ex_illegal  out  1  unsupported opcode.

Function
REQ-003 SHALL register all id_* inputs into the ID/EX register on each rising clk edge when stall=0 and flush=0, giving 1-cycle latency from ID to the EX outputs.
REQ-004 When stall=1 and flush=0, the register SHALL hold its contents.
REQ-005 When flush=1, the SHALL clear ex_valid, ex_regwrite and ex_illegal, regardless of stall; flush SHALL win over stall.
REQ-006 Decode SHALL be registered, and {Ainv,Binv,ALUsel} SHALL be driven from the registered decode as follows.
- OP (0110011) and OP-IMM (0010011), by funct3:
  - 000: 00010 (ADD); OP with funct7b5=1 gives 01010 (SUB).
  - 001: 00110 (SLL).
  - 010: 01100 (SLT).
  - 011: 01011 (SLTU).
  - 100: 00100 (XOR).
  - 101: 00111 (SRL), or 00101 (SRA) if funct7b5=1.
  - 110: 00001 (OR).
  - 111: 00000 (AND).
- OP-IMM funct3=000 SHALL ignore funct7b5.
REQ-007 LUI (0110111), AUIPC (0010111), LOAD (0000011) and STORE (0100011) SHALL select 00010 (ADD).
REQ-008 Operand A select:
- OP, OP-IMM, LOAD, STORE: forwarded rs1.
- LUI: 0.
- AUIPC: registered pc.
REQ-009 Operand B select:
- OP: forwarded rs2.
- All other decoded opcodes: registered imm.
REQ-010 ex_regwrite SHALL be 1 for valid OP, OP-IMM, LUI, AUIPC and LOAD instructions, and 0 for STORE, illegal and invalid entries.
REQ-011 Any other opcode with id_valid=1 SHALL set ex_illegal=1 and ex_regwrite=0, and SHALL select ADD.
REQ-012 Forwarding SHALL be combinational in the EX stage, for rs1 and rs2 independently:
- If mem_regwrite=1, mem_rd!=0 and mem_rd==rs, use mem_result.
- Otherwise, if wb_regwrite=1, wb_rd!=0 and wb_rd==rs, use wb_result.
- Otherwise, use the registered read data.
REQ-013 When MEM and WB both match the same register, MEM SHALL take priority.
REQ-014 A source index of x0 SHALL never forward.
REQ-015 SrcA, SrcB, Ainv, Binv and ALUsel SHALL be valid whenever ex_valid=1; their values when ex_valid=0 are don't-care except after reset.

Reset
REQ-016 rst=1 SHALL immediately clear every register, independent of clk.
REQ-017 After reset, all outputs SHALL be 0: ex_valid, ex_regwrite, ex_illegal, ex_rd, Ainv, Binv, ALUsel, and the registered pc, imm and data.
REQ-018 Reset asserted mid-stall or mid-flush SHALL take precedence over both.
REQ-019 The first capture after reset SHALL occur on the first rising edge with rst=0.

Configuration
REQ-020 With macro RISCV_EX_FORWARD_EN defined, the forwarding of REQ-012 to REQ-014 SHALL be present.
REQ-021 With RISCV_EX_FORWARD_EN undefined, SrcA and SrcB SHALL use only the registered read data, and the mem_* and wb_* inputs SHALL be ignored (ports still present).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- OP SUB, rs1_data=10, rs2_data=3, funct7b5=1, no hazards -> next cycle SrcA=10, SrcB=3, {Ainv,Binv,ALUsel}=01010, ex_regwrite=1.
- OP-IMM ADDI, rs1=x5, imm=-4, mem_regwrite=1, mem_rd=5, mem_result=100, wb_rd=5, wb_result=7 -> SrcA=100 (MEM wins), SrcB=0xFFFFFFFC.
- rs1=x0, mem_rd=0, mem_regwrite=1, mem_result=0xDEAD -> SrcA=registered rs1_data, not 0xDEAD.
- LUI with imm=0x12345000 -> SrcA=0, SrcB=0x12345000, ALU code 00010; AUIPC with pc=0x100, imm=0x1000 -> SrcA=0x100.
- stall=1 for 2 cycles, then stall=1 and flush=1 together -> outputs held for 2 cycles, then ex_valid=0 and ex_regwrite=0.
- Opcode 1110011 with id_valid=1 -> ex_illegal=1, ex_regwrite=0; rst asserted mid-cycle -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/riscv_ex_operand_stage.sv
// ID/EX pipeline register with registered ALU decode and EX-stage operand selection.
// Define RISCV_EX_FORWARD_EN to enable MEM/WB -> EX operand forwarding.
module riscv_ex_operand_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [6:0]  id_opcode,
  input  logic [2:0]  id_funct3,
  input  logic        id_funct7b5,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic [31:0] mem_result,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  input  logic [31:0] wb_result,
  output logic        ex_valid,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic        Ainv,
  output logic        Binv,
  output logic [2:0]  ALUsel,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_illegal
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [4:0] ALU_ADD   = 5'b00010;

  typedef enum logic [1:0] {A_RS1 = 2'd0, A_ZERO = 2'd1, A_PC = 2'd2} asel_e;

  // {Ainv, Binv, ALUsel} for the OP / OP-IMM funct3 space
  function automatic logic [4:0] op_alu(input logic [2:0] f3, input logic f7, input logic is_reg);
    case (f3)
      3'b000:  op_alu = (is_reg && f7) ? 5'b01010 : 5'b00010;
      3'b001:  op_alu = 5'b00110;
      3'b010:  op_alu = 5'b01100;
      3'b011:  op_alu = 5'b01011;
      3'b100:  op_alu = 5'b00100;
      3'b101:  op_alu = f7 ? 5'b00101 : 5'b00111;
      3'b110:  op_alu = 5'b00001;
      default: op_alu = 5'b00000;
    endcase
  endfunction

  logic [4:0]  alu_d, alu_q;
  asel_e       asel_d, asel_q;
  logic        bimm_d, bimm_q;
  logic        rw_d, rw_q;
  logic        ill_d, ill_q;
  logic        valid_q;
  logic [31:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [31:0] rs1_fwd, rs2_fwd;

  always_comb begin
    alu_d  = ALU_ADD;
    asel_d = A_RS1;
    bimm_d = 1'b1;
    rw_d   = 1'b0;
    ill_d  = 1'b0;
    case (id_opcode)
      OPC_OP: begin
        alu_d  = op_alu(id_funct3, id_funct7b5, 1'b1);
        bimm_d = 1'b0;
        rw_d   = id_valid;
      end
      OPC_OPIMM: begin
        alu_d = op_alu(id_funct3, id_funct7b5, 1'b0);
        rw_d  = id_valid;
      end
      OPC_LUI: begin
        asel_d = A_ZERO;
        rw_d   = id_valid;
      end
      OPC_AUIPC: begin
        asel_d = A_PC;
        rw_d   = id_valid;
      end
      OPC_LOAD:  rw_d = id_valid;
      OPC_STORE: rw_d = 1'b0;
      default:   ill_d = id_valid;
    endcase
  end

  // Flush only kills the control bits; the datapath fields are don't-care while invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rw_q       <= 1'b0;
      ill_q      <= 1'b0;
      alu_q      <= 5'd0;
      asel_q     <= A_RS1;
      bimm_q     <= 1'b0;
      pc_q       <= 32'd0;
      rs1_data_q <= 32'd0;
      rs2_data_q <= 32'd0;
      imm_q      <= 32'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
    end else if (flush) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (!stall) begin
      valid_q    <= id_valid;
      rw_q       <= rw_d;
      ill_q      <= ill_d;
      alu_q      <= alu_d;
      asel_q     <= asel_d;
      bimm_q     <= bimm_d;
      pc_q       <= id_pc;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      imm_q      <= id_imm;
      rs1_q      <= id_rs1;
      rs2_q      <= id_rs2;
      rd_q       <= id_rd;
    end
  end

`ifdef RISCV_EX_FORWARD_EN
  // MEM is the younger producer, so it is checked first
  assign rs1_fwd = (mem_regwrite && mem_rd != 5'd0 && mem_rd == rs1_q) ? mem_result :
                   (wb_regwrite  && wb_rd  != 5'd0 && wb_rd  == rs1_q) ? wb_result  : rs1_data_q;
  assign rs2_fwd = (mem_regwrite && mem_rd != 5'd0 && mem_rd == rs2_q) ? mem_result :
                   (wb_regwrite  && wb_rd  != 5'd0 && wb_rd  == rs2_q) ? wb_result  : rs2_data_q;
`else
  logic unused_fwd;
  assign unused_fwd = ^{mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result, rs1_q, rs2_q};
  assign rs1_fwd    = rs1_data_q;
  assign rs2_fwd    = rs2_data_q;
`endif

  always_comb begin
    SrcA = rs1_fwd;
    case (asel_q)
      A_ZERO:  SrcA = 32'd0;
      A_PC:    SrcA = pc_q;
      default: SrcA = rs1_fwd;
    endcase
  end

  assign SrcB                 = bimm_q ? imm_q : rs2_fwd;
  assign {Ainv, Binv, ALUsel} = alu_q;
  assign ex_valid             = valid_q;
  assign ex_regwrite          = rw_q;
  assign ex_illegal           = ill_q;
  assign ex_rd                = rd_q;

endmodule

// File: tb/tb_riscv_ex_operand_stage.sv
// Randomized plus directed bench for riscv_ex_operand_stage against an instruction-level model.
// Expectations follow RISCV_EX_FORWARD_EN the same way the design does.
module tb_riscv_ex_operand_stage;

  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] OPI   = 7'b0010011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] SYS   = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [6:0]  id_opcode = '0;
  logic [2:0]  id_funct3 = '0;
  logic        id_funct7b5 = 1'b0;
  logic [4:0]  mem_rd = '0, wb_rd = '0;
  logic        mem_regwrite = 1'b0, wb_regwrite = 1'b0;
  logic [31:0] mem_result = '0, wb_result = '0;
  logic        ex_valid, Ainv, Binv, ex_regwrite, ex_illegal;
  logic [31:0] SrcA, SrcB;
  logic [2:0]  ALUsel;
  logic [4:0]  ex_rd;

  int vecs = 0;
  int errs = 0;

  riscv_ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
    .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB), .Ainv(Ainv), .Binv(Binv),
    .ALUsel(ALUsel), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the instruction currently held in EX, as raw ID fields
  logic        m_valid = 1'b0, m_clean = 1'b1;
  logic [31:0] m_pc = '0, m_a = '0, m_b = '0, m_imm = '0;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic [6:0]  m_op = '0;
  logic [2:0]  m_f3 = '0;
  logic        m_f7 = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0; m_clean = 1'b1; m_pc = '0; m_a = '0; m_b = '0; m_imm = '0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_op = '0; m_f3 = '0; m_f7 = 1'b0;
    end else if (flush) begin
      m_valid = 1'b0; m_clean = 1'b0;
    end else if (!stall) begin
      m_valid = id_valid; m_clean = 1'b0; m_pc = id_pc; m_a = id_rs1_data; m_b = id_rs2_data;
      m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_op = id_opcode; m_f3 = id_funct3; m_f7 = id_funct7b5;
    end
  end

  function automatic bit writes_reg(input logic [6:0] op);
    return op == OP || op == OPI || op == LUI || op == AUIPC || op == LOAD;
  endfunction

  function automatic logic [4:0] exp_code(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    logic [4:0] tbl [8];
    tbl = '{5'b00010, 5'b00110, 5'b01100, 5'b01011, 5'b00100, 5'b00111, 5'b00001, 5'b00000};
    if (op != OP && op != OPI) return 5'b00010;
    if (f3 == 3'd0 && op == OP && f7) return 5'b01010;
    if (f3 == 3'd5 && f7) return 5'b00101;
    return tbl[f3];
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
`ifdef RISCV_EX_FORWARD_EN
    if (rs == 5'd0) return rf;
    if (mem_regwrite && mem_rd == rs) return mem_result;
    if (wb_regwrite && wb_rd == rs) return wb_result;
`endif
    return rf;
  endfunction

  always @(negedge clk) begin
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("ex_regwrite", {31'd0, ex_regwrite}, {31'd0, m_valid && writes_reg(m_op)});
    chk("ex_illegal", {31'd0, ex_illegal}, {31'd0, m_valid && !writes_reg(m_op) && m_op != STORE});
    if (m_clean) begin
      chk("rst_rd", {27'd0, ex_rd}, 32'd0);
      chk("rst_code", {27'd0, Ainv, Binv, ALUsel}, 32'd0);
      chk("rst_SrcA", SrcA, 32'd0);
      chk("rst_SrcB", SrcB, 32'd0);
    end else if (m_valid) begin
      chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
      chk("alu_code", {27'd0, Ainv, Binv, ALUsel}, {27'd0, exp_code(m_op, m_f3, m_f7)});
      if (writes_reg(m_op) || m_op == STORE) begin
        chk("SrcA", SrcA, m_op == LUI ? 32'd0 : m_op == AUIPC ? m_pc : fwd(m_rs1, m_a));
        chk("SrcB", SrcB, m_op == OP ? fwd(m_rs2, m_b) : m_imm);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_id(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rs1, input logic [31:0] a, input logic [4:0] rs2,
                        input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rd);
    id_valid = 1'b1; id_opcode = op; id_funct3 = f3; id_funct7b5 = f7;
    id_rs1 = rs1; id_rs1_data = a; id_rs2 = rs2; id_rs2_data = b; id_imm = imm; id_rd = rd;
  endtask

  task automatic no_hazard();
    mem_regwrite = 1'b0; wb_regwrite = 1'b0; mem_rd = '0; wb_rd = '0;
  endtask

  logic [6:0] ops [8];

  initial begin
    ops = '{OP, OPI, LUI, AUIPC, LOAD, STORE, SYS, 7'b1111111};
    rst = 1'b1;
    step();
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_code", {27'd0, Ainv, Binv, ALUsel}, 32'd0);
    rst = 1'b0;

    // OP SUB
    set_id(OP, 3'd0, 1'b1, 5'd1, 32'd10, 5'd2, 32'd3, 32'd0, 5'd6);
    no_hazard();
    step();
    chk("sub_SrcA", SrcA, 32'd10);
    chk("sub_SrcB", SrcB, 32'd3);
    chk("sub_code", {27'd0, Ainv, Binv, ALUsel}, 32'b01010);
    chk("sub_rw", {31'd0, ex_regwrite}, 32'd1);

    // ADDI with MEM and WB both matching rs1
    set_id(OPI, 3'd0, 1'b1, 5'd5, 32'd55, 5'd9, 32'd0, 32'hFFFFFFFC, 5'd7);
    mem_regwrite = 1'b1; mem_rd = 5'd5; mem_result = 32'd100;
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_result = 32'd7;
    step();
`ifdef RISCV_EX_FORWARD_EN
    chk("addi_SrcA", SrcA, 32'd100);
`else
    chk("addi_SrcA", SrcA, 32'd55);
`endif
    chk("addi_SrcB", SrcB, 32'hFFFFFFFC);
    chk("addi_code", {27'd0, Ainv, Binv, ALUsel}, 32'b00010);

    // x0 never forwards
    set_id(OPI, 3'd0, 1'b0, 5'd0, 32'h33, 5'd0, 32'd0, 32'd1, 5'd8);
    no_hazard();
    mem_regwrite = 1'b1; mem_rd = 5'd0; mem_result = 32'hDEAD;
    step();
    chk("x0_SrcA", SrcA, 32'h33);

    no_hazard();
    set_id(LUI, 3'd0, 1'b0, 5'd3, 32'h55, 5'd0, 32'd0, 32'h12345000, 5'd9);
    step();
    chk("lui_SrcA", SrcA, 32'd0);
    chk("lui_SrcB", SrcB, 32'h12345000);
    chk("lui_code", {27'd0, Ainv, Binv, ALUsel}, 32'b00010);
    set_id(AUIPC, 3'd0, 1'b0, 5'd3, 32'h55, 5'd0, 32'd0, 32'h1000, 5'd9);
    id_pc = 32'h100;
    step();
    chk("auipc_SrcA", SrcA, 32'h100);
    chk("auipc_SrcB", SrcB, 32'h1000);

    // Stall twice, then stall+flush
    set_id(OP, 3'd6, 1'b0, 5'd1, 32'd7, 5'd2, 32'd9, 32'd0, 5'd3);
    step();
    stall = 1'b1;
    set_id(OP, 3'd0, 1'b0, 5'd1, 32'd99, 5'd2, 32'd98, 32'd0, 5'd4);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_SrcA", SrcA, 32'd7);
      chk("stall_rd", {27'd0, ex_rd}, 32'd3);
      chk("stall_valid", {31'd0, ex_valid}, 32'd1);
    end
    flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_rw", {31'd0, ex_regwrite}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Illegal opcode, then reset asserted mid-cycle
    set_id(SYS, 3'd0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd5);
    step();
    chk("ill_flag", {31'd0, ex_illegal}, 32'd1);
    chk("ill_rw", {31'd0, ex_regwrite}, 32'd0);
    set_id(OP, 3'd0, 1'b0, 5'd1, 32'h11, 5'd2, 32'h22, 32'h33, 5'd5);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    stall = 1'b1; flush = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_rd", {27'd0, ex_rd}, 32'd0);
    chk("arst_SrcA", SrcA, 32'd0);
    chk("arst_SrcB", SrcB, 32'd0);
    chk("arst_code", {27'd0, Ainv, Binv, ALUsel}, 32'd0);
    step();
    stall = 1'b0; flush = 1'b0; rst = 1'b0;
    set_id(LUI, 3'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h00ABC000, 5'd4);
    step();
    chk("first_cap_valid", {31'd0, ex_valid}, 32'd1);
    chk("first_cap_SrcB", SrcB, 32'h00ABC000);

    // Randomized traffic with small register indices to provoke hazards
    for (int n = 0; n < 500; n++) begin
      id_valid     = ($urandom_range(0, 9) != 0);
      id_opcode    = ops[$urandom_range(0, 7)];
      id_funct3    = 3'($urandom);
      id_funct7b5  = 1'($urandom);
      id_pc        = $urandom;
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_rd        = 5'($urandom);
      stall        = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      mem_regwrite = 1'($urandom);
      wb_regwrite  = 1'($urandom);
      mem_rd       = 5'($urandom_range(0, 3));
      wb_rd        = 5'($urandom_range(0, 3));
      mem_result   = $urandom;
      wb_result    = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
